// File: rtl/iopmp_pkg.sv
// Shared IOPMP types used by the check port and its arbiter.
package iopmp_pkg;

  typedef enum logic [1:0] {
    ACCESS_NONE      = 2'b00,
    ACCESS_READ      = 2'b01,
    ACCESS_WRITE     = 2'b10,
    ACCESS_EXECUTION = 2'b11
  } iopmp_access_t;

endpackage

// File: rtl/iopmp_check_arbiter.sv
// Round-robin arbiter sharing the single IOPMP check port between DMA requesters.
// One check in flight; the SID of a check is the index of the granted master.
module iopmp_check_arbiter
  import iopmp_pkg::*;
#(
  parameter int unsigned NR_MASTERS = 2,
  parameter int unsigned PLEN       = 56,
  parameter int unsigned SID_W      = $clog2(NR_MASTERS),
  parameter int unsigned CHECK_LAT  = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NR_MASTERS-1:0]      req_valid_i,
  output logic [NR_MASTERS-1:0]      req_ready_o,
  input  logic [NR_MASTERS*PLEN-1:0] req_addr_i,
  input  iopmp_access_t              req_access_i [NR_MASTERS],
  output logic [NR_MASTERS-1:0]      rsp_valid_o,
  input  logic [NR_MASTERS-1:0]      rsp_ready_i,
  output logic                       rsp_allow_o,
  output logic [PLEN-1:0]            iopmp_addr_o,
  output logic [SID_W-1:0]           iopmp_sid_o,
  output iopmp_access_t              iopmp_access_o,
  input  logic                       iopmp_allow_i,
  output logic                       busy_o
);

  localparam int unsigned CNT_W = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;
  localparam int unsigned PW    = SID_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    RESP  = 2'b10
  } state_t;

  state_t            state_q;
  logic [SID_W-1:0]  ptr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              gnt_valid;
  logic [SID_W-1:0]  gnt_idx;
  logic [PW-1:0]     scan;
  logic [PLEN-1:0]   gnt_addr;
  iopmp_access_t     gnt_access;

  // First requesting master at or above the round-robin pointer, wrapping.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int unsigned i = 0; i < NR_MASTERS; i++) begin
      scan = {1'b0, ptr_q} + PW'(i);
      if (scan >= PW'(NR_MASTERS)) begin
        scan = scan - PW'(NR_MASTERS);
      end
      if (!gnt_valid && req_valid_i[scan[SID_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = scan[SID_W-1:0];
      end
    end
  end

  // Select the granted master's address and access type.
  always_comb begin
    gnt_addr   = '0;
    gnt_access = ACCESS_NONE;
    for (int unsigned m = 0; m < NR_MASTERS; m++) begin
      if (gnt_idx == SID_W'(m)) begin
        gnt_addr   = req_addr_i[m*PLEN +: PLEN];
        gnt_access = req_access_i[m];
      end
    end
  end

  // Accept strobe goes to the winner only, and only while idle.
  always_comb begin
    req_ready_o = '0;
    if (!rst_i && (state_q == IDLE) && gnt_valid) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  assign busy_o = (state_q != IDLE);

  // Check sequencer: latch the grant, hold the iopmp inputs, sample the verdict, respond.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      cnt_q          <= '0;
      rsp_valid_o    <= '0;
      rsp_allow_o    <= 1'b0;
      iopmp_addr_o   <= '0;
      iopmp_sid_o    <= '0;
      iopmp_access_o <= ACCESS_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            iopmp_addr_o   <= gnt_addr;
            iopmp_access_o <= gnt_access;
            iopmp_sid_o    <= gnt_idx;
            cnt_q          <= '0;
            state_q        <= CHECK;
          end
        end
        CHECK: begin
          if (cnt_q == CNT_W'(CHECK_LAT - 1)) begin
            // An access type of NONE never grants, whatever the iopmp says.
            rsp_allow_o    <= (iopmp_access_o != ACCESS_NONE) && iopmp_allow_i;
            rsp_valid_o    <= NR_MASTERS'(1) << iopmp_sid_o;
            iopmp_access_o <= ACCESS_NONE;
            state_q        <= RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i[iopmp_sid_o]) begin
            rsp_valid_o <= '0;
            if (iopmp_sid_o == SID_W'(NR_MASTERS - 1)) begin
              ptr_q <= '0;
            end else begin
              ptr_q <= iopmp_sid_o + SID_W'(1);
            end
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
